// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared constants and types for the two-requester round-robin packet mux.
//   DW_DEFAULT : default beat data width
//   ST_*       : FSM state codes (two-bit encoding)
//   state_e    : typed FSM state built on those codes
package mux2_arb_pkg;

  localparam int unsigned DW_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StGnt0 = ST_GNT0,
    StGnt1 = ST_GNT1
  } state_e;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// mux2_rr_arbiter_if: bundle of the two producer streams, the consumer stream and status.
//   req0_* / req1_* : producer valid/data/last in, ready out
//   out_*           : consumer valid/data/last out, ready in
//   sel, busy       : registered mux select and grant-active flag
//   timeout         : one-cycle idle-timeout pulse (only with MUX2_ARB_TIMEOUT_EN)
// Modports: master = the arbiter itself, slave = the surrounding producers/consumer.
interface mux2_rr_arbiter_if
  import mux2_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
);
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_last;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_last;
  logic          req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          sel;
  logic          busy;
`ifdef MUX2_ARB_TIMEOUT_EN
  logic          timeout;
`endif

  modport master (
    input  req0_valid, req0_data, req0_last,
    output req0_ready,
    input  req1_valid, req1_data, req1_last,
    output req1_ready,
    output out_valid, out_data, out_last,
    input  out_ready,
`ifdef MUX2_ARB_TIMEOUT_EN
    output timeout,
`endif
    output sel, busy
  );

  modport slave (
    output req0_valid, req0_data, req0_last,
    input  req0_ready,
    output req1_valid, req1_data, req1_last,
    input  req1_ready,
    input  out_valid, out_data, out_last,
    output out_ready,
`ifdef MUX2_ARB_TIMEOUT_EN
    input  timeout,
`endif
    input  sel, busy
  );

endinterface

// File: rtl/mux2_bus.sv
// mux2_bus: W-bit combinational 2:1 mux.
//   sel : 0 selects i0, 1 selects i1
//   i0, i1 : inputs; out : selected value
module mux2_bus #(
  parameter int unsigned W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  output logic [W-1:0] out
);

  assign out = sel ? i1 : i0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: shares one DW-wide 2:1 mux between two packet producers with round-robin
// arbitration. A grant is held until the beat carrying last is accepted, then one idle cycle
// follows before the next grant.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mux2_rr_arbiter_if.master (producer/consumer handshakes, sel, busy)
// Optional feature MUX2_ARB_TIMEOUT_EN: releases a grant after TIMEOUT consecutive granted cycles
// with the owner's valid low, pulsing bus.timeout for one cycle.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst,
  mux2_rr_arbiter_if.master  bus
);

  state_e  state_q;
  logic    sel_q;
  logic    busy_q;
  logic    last_grant_q;

  logic [DW-1:0] data_mux;
  logic [0:0]    last_mux;
  logic [0:0]    valid_mux;
  logic          xfer_last;

  mux2_bus #(.W(DW)) u_data_mux (
    .sel (sel_q),
    .i0  (bus.req0_data),
    .i1  (bus.req1_data),
    .out (data_mux)
  );

  mux2_bus #(.W(1)) u_last_mux (
    .sel (sel_q),
    .i0  (bus.req0_last),
    .i1  (bus.req1_last),
    .out (last_mux)
  );

  mux2_bus #(.W(1)) u_valid_mux (
    .sel (sel_q),
    .i0  (bus.req0_valid),
    .i1  (bus.req1_valid),
    .out (valid_mux)
  );

  // sel only moves on a grant, so gating the mux with busy keeps the idle requester off out_*.
  assign bus.out_valid  = busy_q & valid_mux[0];
  assign bus.out_last   = busy_q & last_mux[0];
  assign bus.out_data   = busy_q ? data_mux : '0;
  assign bus.req0_ready = (state_q == StGnt0) & bus.out_ready;
  assign bus.req1_ready = (state_q == StGnt1) & bus.out_ready;
  assign bus.sel        = sel_q;
  assign bus.busy       = busy_q;

  assign xfer_last = bus.out_valid & bus.out_ready & bus.out_last;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] idle_cnt_q;
  logic            timeout_q;
  assign bus.timeout = timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef MUX2_ARB_TIMEOUT_EN
      idle_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
`ifdef MUX2_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
`ifdef MUX2_ARB_TIMEOUT_EN
          idle_cnt_q <= '0;
`endif
          // On a tie the requester that did not win last time goes first.
          if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
            state_q      <= StGnt0;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b0;
            busy_q       <= 1'b1;
          end else if (bus.req1_valid) begin
            state_q      <= StGnt1;
            sel_q        <= 1'b1;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StGnt0, StGnt1: begin
          if (xfer_last) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
`ifdef MUX2_ARB_TIMEOUT_EN
          else if (!bus.out_valid) begin
            if (idle_cnt_q == CntW'(TIMEOUT - 1)) begin
              state_q    <= StIdle;
              busy_q     <= 1'b0;
              timeout_q  <= 1'b1;
              idle_cnt_q <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end else begin
            idle_cnt_q <= '0;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: self-checking bench for mux2_rr_arbiter. A directed vector table covers
// the packet, tie, stall, waiting-requester and reset cases; random traffic is then checked
// against a behavioural owner/round-robin model. Built with TIMEOUT=4.
module tb_mux2_rr_arbiter;
  import mux2_arb_pkg::*;

  localparam int unsigned DW = 8;
  localparam int TMO = 4;

  logic clk;
  logic rst;

  mux2_rr_arbiter_if #(.DW(DW)) ifc ();

  mux2_rr_arbiter #(.DW(DW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: who owns the output (-1 none), who won last, what sel shows.
  int   owner;
  int   prev;
  logic sel_m;
  int   cnt;
  logic to_m;

  typedef struct {
    logic          rst;
    logic          v0;
    logic [DW-1:0] d0;
    logic          l0;
    logic          v1;
    logic [DW-1:0] d1;
    logic          l1;
    logic          ordy;
    logic [DW+5:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v0, logic [DW-1:0] d0, logic l0, logic v1,
                              logic [DW-1:0] d1, logic l1, logic ordy, logic ev,
                              logic [DW-1:0] ed, logic el, logic er0, logic er1, logic esel,
                              logic ebusy);
    vec_t t;
    t.rst = r; t.v0 = v0; t.d0 = d0; t.l0 = l0; t.v1 = v1; t.d1 = d1; t.l1 = l1;
    t.ordy = ordy;
    t.exp = {ev, ed, el, er0, er1, esel, ebusy};
    return t;
  endfunction

  function automatic logic [DW+5:0] model_exp();
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    if (owner < 0) return {1'b0, {DW{1'b0}}, 1'b0, 1'b0, 1'b0, sel_m, 1'b0};
    v = (owner == 1) ? ifc.req1_valid : ifc.req0_valid;
    d = (owner == 1) ? ifc.req1_data : ifc.req0_data;
    l = (owner == 1) ? ifc.req1_last : ifc.req0_last;
    return {v, d, l, (owner == 0) & ifc.out_ready, (owner == 1) & ifc.out_ready, sel_m, 1'b1};
  endfunction

  task automatic model_tick();
    logic v[2];
    logic l[2];
    v[0] = ifc.req0_valid; v[1] = ifc.req1_valid;
    l[0] = ifc.req0_last;  l[1] = ifc.req1_last;
    to_m = 1'b0;
    if (rst) begin
      owner = -1; prev = 1; sel_m = 1'b0; cnt = 0;
    end else if (owner < 0) begin
      cnt = 0;
      if (v[0] || v[1]) begin
        owner = (v[0] && v[1]) ? 1 - prev : (v[0] ? 0 : 1);
        prev  = owner;
        sel_m = (owner == 1);
      end
    end else if (v[owner] && ifc.out_ready && l[owner]) begin
      owner = -1;
    end else begin
`ifdef MUX2_ARB_TIMEOUT_EN
      if (!v[owner]) begin
        cnt++;
        if (cnt == TMO) begin
          owner = -1; cnt = 0; to_m = 1'b1;
        end
      end else begin
        cnt = 0;
      end
`endif
    end
  endtask

  task automatic check(input logic [DW+5:0] exp, input string name);
    logic [DW+5:0] act;
    act = {ifc.out_valid, ifc.out_data, ifc.out_last, ifc.req0_ready, ifc.req1_ready, ifc.sel,
           ifc.busy};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {v,data,last,r0,r1,sel,busy}=%h, expected %h", name, act, exp);
    end
`ifdef MUX2_ARB_TIMEOUT_EN
    n_vec++;
    if (ifc.timeout !== to_m) begin
      n_err++;
      $display("FAIL %s timeout: got %b, expected %b", name, ifc.timeout, to_m);
    end
`endif
  endtask

  // Inputs are already driven; compare mid-cycle, then advance the model at the edge.
  task automatic step(input logic [DW+5:0] exp, input string name);
    @(negedge clk);
    check(exp, name);
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic drive(input vec_t t);
    rst            = t.rst;
    ifc.req0_valid = t.v0; ifc.req0_data = t.d0; ifc.req0_last = t.l0;
    ifc.req1_valid = t.v1; ifc.req1_data = t.d1; ifc.req1_last = t.l1;
    ifc.out_ready  = t.ordy;
  endtask

  initial begin
    rst = 1'b1;
    ifc.req0_valid = 1'b0; ifc.req0_data = '0; ifc.req0_last = 1'b0;
    ifc.req1_valid = 1'b0; ifc.req1_data = '0; ifc.req1_last = 1'b0;
    ifc.out_ready  = 1'b0;
    owner = -1; prev = 1; sel_m = 1'b0; cnt = 0; to_m = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // req0 3-beat packet after reset
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA1, 0, 0, 8'h00, 0, 1, 1, 8'hA1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'hA2, 0, 0, 8'h00, 0, 1, 1, 8'hA2, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'hA3, 1, 0, 8'h00, 0, 1, 1, 8'hA3, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    // reset, then alternating ties of single-beat packets with a bubble between
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hB0, 1, 1, 8'hC0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hB0, 1, 1, 8'hC0, 1, 1, 1, 8'hB0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'hB1, 1, 1, 8'hC1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hB1, 1, 1, 8'hC1, 1, 1, 1, 8'hC1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 8'hB2, 1, 1, 8'hC2, 1, 1, 0, 8'h00, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hB2, 1, 1, 8'hC2, 1, 1, 1, 8'hB2, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'hB3, 1, 1, 8'hC3, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hB3, 1, 1, 8'hC3, 1, 1, 1, 8'hC3, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0));
    // req0 5-beat packet with a 4-cycle stall and a valid drop; req1 waits throughout
    tbl.push_back(mk(0, 1, 8'hD1, 0, 1, 8'hE1, 1, 1, 0, 8'h00, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hD1, 0, 1, 8'hE1, 1, 1, 1, 8'hD1, 0, 1, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 8'hD2, 0, 1, 8'hE1, 1, 0, 1, 8'hD2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'hD2, 0, 1, 8'hE1, 1, 1, 1, 8'hD2, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'hD3, 0, 1, 8'hE1, 1, 1, 0, 8'hD3, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'hD3, 0, 1, 8'hE1, 1, 1, 1, 8'hD3, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'hD4, 0, 1, 8'hE1, 1, 1, 1, 8'hD4, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'hD5, 1, 1, 8'hE1, 1, 1, 1, 8'hD5, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'hE1, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    // req1 granted; reset on its second beat truncates the packet
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'hE1, 0, 1, 1, 8'hE1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 8'hE2, 0, 1, 1, 8'hE2, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 8'hF0, 1, 1, 8'hE3, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hF0, 1, 1, 8'hE3, 0, 1, 1, 8'hF0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      step(tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Random traffic against the model, starting from a fresh reset.
    rst = 1'b1;
    step(model_exp(), "rand_rst");
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 49) == 0);
      ifc.req0_valid = ($urandom_range(0, 3) != 0);
      ifc.req0_data  = DW'($urandom);
      ifc.req0_last  = ($urandom_range(0, 2) == 0);
      ifc.req1_valid = ($urandom_range(0, 3) != 0);
      ifc.req1_data  = DW'($urandom);
      ifc.req1_last  = ($urandom_range(0, 2) == 0);
      ifc.out_ready  = ($urandom_range(0, 3) != 0);
      step(model_exp(), $sformatf("rand%0d", i));
    end

`ifdef MUX2_ARB_TIMEOUT_EN
    // req0 stalls after its first beat; the grant times out and req1 goes next.
    rst = 1'b1;
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0; ifc.out_ready = 1'b1;
    step(model_exp(), "tmo_rst");
    rst = 1'b0;
    ifc.req0_valid = 1'b1; ifc.req0_data = 8'h11; ifc.req0_last = 1'b0;
    step(model_exp(), "tmo_req");
    step(model_exp(), "tmo_beat1");
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b1; ifc.req1_data = 8'h22; ifc.req1_last = 1'b1;
    for (int i = 0; i < TMO; i++) step(model_exp(), $sformatf("tmo_idle%0d", i));
    @(negedge clk);
    n_vec++;
    if (ifc.timeout !== 1'b1 || ifc.busy !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_pulse: got timeout=%b busy=%b, expected timeout=1 busy=0",
               ifc.timeout, ifc.busy);
    end
    @(posedge clk);
    model_tick();
    #1;
    step({1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}, "tmo_gnt1");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
